// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: MEM-stage data-memory access controller with pipeline stall, alignment and timeout errors
module dmem_stall_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        memStall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, stateNext;
  logic [7:0] cnt;
  logic toFlag, go, timeUp;
  assign go = state == IDLE && en && !addr[0];
  assign timeUp = state == BUSY && !mem_ready && cnt == 8'(TIMEOUT - 1);
  always_comb begin
    stateNext = state == IDLE ? (go ? BUSY : IDLE) :
                state == BUSY ? ((mem_ready || timeUp) ? DONE : BUSY) : IDLE;
    memStall = go || state == BUSY;
    err = (state == IDLE && en && addr[0]) || (state == DONE && toFlag);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= stateNext;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      toFlag <= 1'b0;
      cnt <= '0;
    end else if (go) begin
      mem_addr <= addr;
      mem_wdata <= wdata;
      mem_wr <= wr;
      mem_req <= 1'b1;
      cnt <= '0;
    end else if (state == BUSY) begin
      if (mem_ready) begin
        if (!mem_wr) rdata <= mem_rdata;
        mem_req <= 1'b0;
        mem_wr <= 1'b0;
        toFlag <= 1'b0;
      end else if (timeUp) begin
        rdata <= '0;
        toFlag <= 1'b1;
        mem_req <= 1'b0;
      end else begin
        cnt <= cnt == 8'hFF ? cnt : cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb_dmem_stall_ctrl: directed and randomized accesses checked against a transaction-level model
module tb_dmem_stall_ctrl;
  localparam int TIMEOUT = 4;
  logic clk = 0, rst = 1, en = 0, wr = 0, mem_ready = 0;
  logic [15:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic memStall, err, mem_req, mem_wr;
  logic [15:0] mdlRdata = 0;
  int nChecks = 0, nErrors = 0;

  dmem_stall_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .memStall(memStall), .err(err), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    nChecks++;
    if (got != exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access: lat = BUSY cycle on which memory answers (0 = never)
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int lat, input logic [15:0] rd);
    int k, stall, reqs;
    bit tout;
    @(posedge clk); #1;
    en = 1; wr = w; addr = a; wdata = d; mem_ready = 0;
    #1;
    if (a[0]) begin
      check("misStall", memStall, 0);
      check("misErr", err, 1);
      check("misReq", mem_req, 0);
      @(posedge clk); #1;
      en = 0;
      #1;
      check("misIdleReq", mem_req, 0);
      check("misIdleStall", memStall, 0);
      check("misIdleErr", err, 0);
      return;
    end
    check("reqStall", memStall, 1);
    check("reqErr", err, 0);
    check("reqNoMemReq", mem_req, 0);
    tout = lat == 0 || lat > TIMEOUT;
    stall = 1; reqs = 0; k = 0;
    forever begin
      @(posedge clk); #1;
      k++;
      mem_ready = k == lat;
      mem_rdata = mem_ready ? rd : 16'($urandom);
      #1;
      if (!memStall) break;
      stall++;
      reqs += int'(mem_req);
      if (k == 1) begin
        check("busyAddr", mem_addr, a);
        check("busyWr", mem_wr, w);
        if (w) check("busyWdata", mem_wdata, d);
      end
      if (k > TIMEOUT + 3) begin
        check("busyBound", k, TIMEOUT + 1);
        break;
      end
    end
    if (tout) mdlRdata = 0;
    else if (!w) mdlRdata = rd;
    check("stallCycles", stall, tout ? 1 + TIMEOUT : 1 + lat);
    check("reqCycles", reqs, stall - 1);
    check("doneRdata", rdata, mdlRdata);
    check("doneErr", err, tout);
    check("doneReq", mem_req, 0);
    if (!tout) check("doneWr", mem_wr, 0);
    en = 0;
    mem_ready = 1;
    mem_rdata = 16'hDEAD;
  endtask

  initial begin
    #2;
    check("rstStall", memStall, 0);
    check("rstErr", err, 0);
    check("rstReq", mem_req, 0);
    check("rstRdata", rdata, 0);
    check("rstAddr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 0;
    access(0, 16'h0010, 16'h0000, 3, 16'hBEEF);
    access(1, 16'h0020, 16'h1234, 1, 16'h0000);
    access(0, 16'h0011, 16'h0000, 1, 16'h0000);
    access(0, 16'h0030, 16'h0000, 0, 16'h0000);
    @(posedge clk); #2;
    check("lateReadyIdle", memStall, 0);
    check("lateReadyRdata", rdata, 0);
    mem_ready = 0;
    access(0, 16'h0002, 16'h0000, 1, 16'h1111);
    access(0, 16'h0004, 16'h0000, 1, 16'h2222);
    @(posedge clk); #1;
    en = 1; wr = 0; addr = 16'h0040; mem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("preRstReq", mem_req, 1);
    en = 0; rst = 1;
    #1;
    check("asyncRstReq", mem_req, 0);
    check("asyncRstStall", memStall, 0);
    check("asyncRstRdata", rdata, 0);
    mdlRdata = 0;
    #2 rst = 0;
    access(0, 16'h0040, 16'h0000, 2, 16'h5A5A);
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      access(1'($urandom), a, 16'($urandom), $urandom_range(0, TIMEOUT + 2), 16'($urandom));
    end
    @(posedge clk); #1;
    mem_ready = 0;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule

// File: doc/dmem_stall_ctrl.md
# dmem_stall_ctrl

Data-memory access controller for the MEM stage. Accepts one load or store per instruction from the EX/MEM pipeline register and runs it against a multi-cycle data memory over a req/ready handshake. Drives `memStall`, which freezes the MEM/WB register and everything upstream while an access is in flight. Returns load data with alignment and timeout error flags.

## Interface

Parameters:
- `TIMEOUT`, default 255: max BUSY cycles waiting for `mem_ready` before aborting; 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `en`  in  1  MEM stage holds a memory instruction; held stable while `memStall`=1.
- `wr`  in  1  1=store, 0=load; valid with `en`.
- `addr`  in  16  byte address; valid with `en`.
- `wdata`  in  16  store data; valid with `en`.
- `rdata`  out  16  load data, valid in DONE.
- `memStall`  out  1  stall pipeline; combinational from state and inputs.
- `err`  out  1  misaligned access (combinational) or timeout (in DONE).
- `mem_req`  out  1  memory request, registered.
- `mem_wr`  out  1  memory write strobe, registered.
- `mem_addr`  out  16  registered address to memory.
- `mem_wdata`  out  16  registered write data to memory.
- `mem_rdata`  in  16  memory read data, valid when `mem_ready`=1.
- `mem_ready`  in  1  memory completes the current request this cycle.

## Operation

- States: IDLE, BUSY, DONE. Reset state: IDLE.
- IDLE:
  - `en`=0: `memStall`=0, no action.
  - `en`=1, `addr[0]`=1 (misaligned): `memStall`=0, `err`=1, no memory access, stay IDLE.
  - `en`=1, `addr[0]`=0: `memStall`=1. On the clock edge, latch `addr`, `wdata`, `wr` into `mem_addr`, `mem_wdata`, `mem_wr`. Set `mem_req`=1 and clear the timeout counter. Go to BUSY.
- BUSY:
  - `memStall`=1 and `mem_req`=1.
  - `mem_ready`=1: latch `mem_rdata` into `rdata` (loads only; stores leave `rdata` unchanged), clear `mem_req` and `mem_wr`, go to DONE with the error flag cleared.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`-1 without `mem_ready`: set `rdata`=0, set the error flag, clear `mem_req`, go to DONE.
- DONE:
  - `memStall`=0. `rdata` is valid. `err` equals the latched timeout flag.
  - The pipeline advances on this edge; MEM/WB captures `rdata`. Always return to IDLE next cycle, regardless of `en`, so no access is ever re-issued.
- `mem_ready` is ignored outside BUSY.
- The counter is 8 bits and saturates; it never wraps.
- Stores complete the same way as loads; `rdata` is don't-care for the pipeline.

## Timing

- Reset values: state=IDLE, `mem_req`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0, timeout flag=0. Combinational outputs follow: `memStall`=0 and `err`=0 when `en`=0.
- Aligned access latency, with N = cycles from the first BUSY cycle to `mem_ready`, inclusive:
  - `memStall` high for 1+N cycles (the IDLE request cycle plus N BUSY cycles).
  - DONE follows with `memStall` low.
  - Minimum case: `mem_ready` in the first BUSY cycle gives 2 stall cycles and a 3-cycle total.
- Timeout: `memStall` high for 1+`TIMEOUT` cycles, then DONE with `err`=1.
- Back-to-back accesses: DONE, then IDLE sees the new `en`. There is one non-stalled IDLE-or-DONE cycle between accesses.
- `mem_req` stays asserted continuously from the first BUSY cycle until the edge where `mem_ready` is sampled; it drops the next cycle.
- Asynchronous `rst` mid-BUSY: `mem_req` drops immediately and state returns to IDLE. An in-flight memory response is discarded.

## Test plan

- Load, `addr`=0x0010, memory returns 0xBEEF with `mem_ready` on the 3rd BUSY cycle -> `memStall` high 4 cycles, then DONE with `rdata`=0xBEEF, `err`=0; `mem_req` high exactly 3 cycles.
- Store, `addr`=0x0020, `wdata`=0x1234, `mem_ready` on the 1st BUSY cycle -> `mem_addr`=0x0020, `mem_wdata`=0x1234, `mem_wr`=1 during BUSY; 2 stall cycles; `err`=0.
- Misaligned load, `addr`=0x0011 -> `memStall`=0, `err`=1 in the same cycle, `mem_req` never asserts.
- `TIMEOUT`=4, `mem_ready` held 0 -> 5 stall cycles, then DONE with `rdata`=0x0000, `err`=1; a late `mem_ready` in DONE or IDLE is ignored.
- Back-to-back loads to 0x0002 then 0x0004 (data 0x1111, 0x2222, immediate ready) -> exactly two requests, one non-stalled cycle between them, `rdata` 0x1111 then 0x2222.
- Assert `rst` asynchronously in the 2nd BUSY cycle -> `mem_req`=0, `memStall`=0 immediately; the next `en` starts a fresh access.
